// File: rtl/tone_pkg.sv
// Shared types and constants for the buzzer tone scheduler.
package tone_pkg;

    typedef logic [2:0]  note_idx_t;
    typedef logic [18:0] period_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } tone_state_t;

    // C4, D4, E4, F4, G4 half... full PWM periods in 100 MHz clk cycles
    localparam period_t PERIOD_TBL [5] = '{
        19'd382219, 19'd340530, 19'd303370, 19'd286344, 19'd255102
    };

    function automatic period_t note_period(input note_idx_t idx);
        case (idx)
            3'd0:    return PERIOD_TBL[0];
            3'd1:    return PERIOD_TBL[1];
            3'd2:    return PERIOD_TBL[2];
            3'd3:    return PERIOD_TBL[3];
            3'd4:    return PERIOD_TBL[4];
            default: return PERIOD_TBL[0];
        endcase
    endfunction

endpackage

// File: rtl/tone_fifo.sv
// Small synchronous FIFO for note events; pointers carry one extra wrap bit.
module tone_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/tone_scheduler.sv
// Button-to-buzzer note sequencer: edge detect, arbiter, event FIFO, play/gap FSM.
// Define TONE_SCHED_PREEMPT_EN to turn btnDb[4] into a stop key that flushes everything.
module tone_scheduler
    import tone_pkg::*;
#(
    parameter int unsigned TONE_MS = 200,
    parameter int unsigned GAP_MS  = 50,
    parameter int unsigned QDEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [4:0]  btnDb,
    output logic        tone_en,
    output logic [18:0] tone_period,
    output logic [2:0]  tone_idx,
    output logic        busy,
    output logic        q_full
);

    localparam logic [15:0] TONE_LAST = 16'(TONE_MS - 1);
    localparam logic [15:0] GAP_LAST  = (GAP_MS == 0) ? 16'd0 : 16'(GAP_MS - 1);

    tone_state_t state;
    logic [15:0] cnt;
    logic [4:0]  btn_prev;
    logic [4:0]  rise;
    logic [4:0]  note_rise;
    logic [4:0]  pending;
    logic [4:0]  grant;
    note_idx_t   grant_idx;
    note_idx_t   q_dout;
    logic        q_empty;
    logic        push;
    logic        pop;
    logic        stop;

    assign rise = btnDb & ~btn_prev;

`ifdef TONE_SCHED_PREEMPT_EN
    assign stop      = rise[4];
    assign note_rise = {1'b0, rise[3:0]};
`else
    assign stop      = 1'b0;
    assign note_rise = rise;
`endif

    // Lowest pending bit wins; nothing is granted while the FIFO is full.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (!q_full && (pending != '0) && !stop) begin
            for (int unsigned i = 0; i < 5; i++) begin
                if (pending[i] && (grant == '0)) begin
                    grant[i]  = 1'b1;
                    grant_idx = 3'(i);
                end
            end
        end
    end

    assign push = (grant != '0);
    assign pop  = (state == IDLE) && !q_empty && !stop;
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev <= '1;
            pending  <= '0;
        end else begin
            btn_prev <= btnDb;
            pending  <= stop ? 5'd0 : ((pending | note_rise) & ~grant);
        end
    end

    tone_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (stop),
        .push  (push),
        .din   (grant_idx),
        .pop   (pop),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            tone_en     <= 1'b0;
            tone_idx    <= '0;
            tone_period <= PERIOD_TBL[0];
        end else if (stop) begin
            state   <= IDLE;
            cnt     <= '0;
            tone_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!q_empty) begin
                        tone_idx    <= q_dout;
                        tone_period <= note_period(q_dout);
                        tone_en     <= 1'b1;
                        cnt         <= '0;
                        state       <= PLAY;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        if (cnt == TONE_LAST) begin
                            tone_en <= 1'b0;
                            cnt     <= '0;
                            state   <= (GAP_MS == 0) ? IDLE : GAP;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (cnt == GAP_LAST) state <= IDLE;
                        else                 cnt   <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tone_scheduler.md
# tone_scheduler

Sequences the piezo buzzer from the debounced button bank. Converts debounced button presses into note events, arbitrates simultaneous presses, buffers them in a small FIFO, and plays each note for a fixed number of 1 ms ticks followed by a silent gap. Sits between the button debouncer and the buzzer PWM generator, and drives the PWM's enable and period inputs.

## Interface
- TONE_MS, 200: note length in `tick` periods (≥1)
- GAP_MS, 50: silence after each note in `tick` periods (0 = no gap)
- QDEPTH, 4: event FIFO depth, power of two (≥2)
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset, synchronous, active-high
- tick  in  1  1 ms single-cycle strobe, shared with the debouncer
- btnDb  in  5  debounced buttons; bit i selects note i
- tone_en  out  1  PWM enable
- tone_period  out  19  PWM period in clk cycles for the current note
- tone_idx  out  3  index of the current note, 0–4
- busy  out  1  high whenever state ≠ IDLE
- q_full  out  1  FIFO full

## Operation
- Edge detect: `rise = btnDb & ~btn_prev`; `btn_prev <= btnDb` every cycle. `btn_prev` resets to 5'b11111, so buttons held through reset do not fire.
- Pending mask (5 bits), updated each cycle: `pending <= (pending | rise) & ~grant`.
  - A rise on a bit that is already pending merges into it; no duplicate event is created.
- Arbiter: when the FIFO is not full and `pending ≠ 0`, grant the lowest set bit and push its index.
  - When the FIFO is full, no grant is made and `pending` holds.
- FIFO: QDEPTH × 3 bits, with read and write pointers one bit wider than the address.
  - Push and pop in the same cycle are both allowed.
- FSM (`cnt` is 16 bits):
  - **IDLE**: if the FIFO is not empty, pop, latch `tone_idx`, set `tone_en=1`, clear `cnt`, go to PLAY.
  - **PLAY**: on each tick, `cnt++`. On the tick where `cnt == TONE_MS-1`: `tone_en=0`, clear `cnt`, go to GAP. If GAP_MS=0, go to IDLE instead.
  - **GAP**: on each tick, `cnt++`. On the tick where `cnt == GAP_MS-1`, go to IDLE.
- `tone_period = PERIOD_TBL[tone_idx]`, registered. Table: 382219, 340530, 303370, 286344, 255102 (C4–G4 at 100 MHz).
- Reset values: `tone_en=0`, `tone_idx=0`, `tone_period=PERIOD_TBL[0]`, `busy=0`, `q_full=0`. FIFO is emptied, `pending=0`, state is IDLE.
  - A reset asserted mid-note silences the buzzer on the next edge.

## Timing
- Latency: btnDb[i] sampled high at edge k, with the FSM IDLE and the FIFO empty:
  - edge k: pending set
  - edge k+1: pushed
  - edge k+2: `tone_en=1`
- Note length: exactly TONE_MS ticks. `tone_en` falls at the edge that samples the TONE_MS-th tick after entry.
  - A tick coincident with entry into PLAY is not counted.
- Back-to-back notes: the next note starts one cycle after GAP ends (one cycle after PLAY ends when GAP_MS=0).
- `tick` is ignored in IDLE.
- `q_full` is registered, consistent with the pointers after each edge.

## Configuration
- `TONE_SCHED_PREEMPT_EN` defined: btnDb[4] is a stop key, not a note.
  - On its rise, in the same cycle, `pending` and the FIFO are flushed, and the FSM goes to IDLE with `tone_en=0` from any state.
  - Bit 4 is never pushed.
  - A stop rise coincident with other rises discards them all.
- Not defined: btnDb[4] is note 4 (G4) like the others.

## Structure
- Package `tone_pkg`:
  - `PERIOD_TBL` constants
  - note index type (3 bits)
  - FSM state enum `{IDLE, PLAY, GAP}`
- Sub-module `tone_fifo` (parameterised by depth and width, with full/empty outputs) is natural. Arbiter and FSM stay in `tone_scheduler`.

## Test plan
- Reset with btnDb=5'b00100 held, then release and run 300 ticks → no `tone_en`, `busy=0`.
- Rise on btnDb[2] with the block idle → `tone_en=1` at edge k+2 with `tone_period=303370`. It stays high for 200 ticks, then 50 silent ticks, then `busy=0`.
- btnDb[3] and btnDb[1] rise in the same cycle → notes play in order 1 then 3 (periods 340530, 286344), separated by one gap.
- Press notes 0,1,2,3,4 then 0 again during the first note → FIFO fills (`q_full=1`) and the remainder stays pending. All notes play in order, with no loss and no duplicates of the re-pressed 0 while it is pending.
- With `TONE_SCHED_PREEMPT_EN`: queue three notes, rise btnDb[4] mid-PLAY → `tone_en=0` next edge, FIFO empty, `busy=0`, no further notes.
- With TONE_MS=1 and GAP_MS=0: two queued notes → each `tone_en` pulse lasts exactly one tick interval, and the second starts one cycle after the first ends.
